// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns the HI/LO pair and models fixed
// multi-cycle mult/div latency with a down-counter that drives E_Busy.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_Start,
    input  logic [2:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_Req,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // 32x32 -> 64 product; the truncated 64-bit product of the extended
    // operands is exact for both the signed and unsigned interpretation.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        if (is_signed) begin
            ax = {{32{a[31]}}, a};
            bx = {{32{b[31]}}, b};
        end else begin
            ax = {32'd0, a};
            bx = {32'd0, b};
        end
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; done on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 without relying on tool behaviour.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        if (neg_a ^ neg_b) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (neg_a) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic [31:0]      hi_nxt_s;
    logic [31:0]      lo_nxt_s;
    logic [31:0]      pend_hi_nxt_s;
    logic [31:0]      pend_lo_nxt_s;
    logic             accept_s;
    logic [63:0]      prod_s;
    logic [63:0]      quot_rem_s;
    logic             op_signed_s;

    assign accept_s    = E_Start & ~E_Req & (cnt_r == {CNT_W{1'b0}});
    assign op_signed_s = (E_MDUOp == OP_MULT) | (E_MDUOp == OP_DIV);
    assign prod_s      = mul64(E_A, E_B, op_signed_s);
    assign quot_rem_s  = div64(E_A, E_B, op_signed_s);

    // Next-state decode: accept a new op when idle, otherwise count down and commit.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        pend_hi_nxt_s = pend_hi_r;
        pend_lo_nxt_s = pend_lo_r;
        if (accept_s) begin
            case (E_MDUOp)
                OP_MULT, OP_MULTU: begin
                    pend_hi_nxt_s = prod_s[63:32];
                    pend_lo_nxt_s = prod_s[31:0];
                    cnt_nxt_s     = CNT_W'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    // A zero divisor re-commits the current HI/LO unchanged.
                    if (E_B == 32'd0) begin
                        pend_hi_nxt_s = hi_r;
                        pend_lo_nxt_s = lo_r;
                    end else begin
                        pend_hi_nxt_s = quot_rem_s[63:32];
                        pend_lo_nxt_s = quot_rem_s[31:0];
                    end
                    cnt_nxt_s = CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: hi_nxt_s = E_A;
                OP_MTLO: lo_nxt_s = E_A;
                OP_NONE: cnt_nxt_s = cnt_r;
                default: cnt_nxt_s = cnt_r;
            endcase
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                hi_nxt_s = pend_hi_r;
                lo_nxt_s = pend_lo_r;
            end else begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            busy_r    <= (cnt_nxt_s != {CNT_W{1'b0}});
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            pend_hi_r <= pend_hi_nxt_s;
            pend_lo_r <= pend_lo_nxt_s;
        end
    end

    assign E_Busy = busy_r;
    assign E_HI   = hi_r;
    assign E_LO   = lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized self-checking bench for e_mdu against a timestamp-based
// reference model using plain 64-bit signed/unsigned arithmetic.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_Start;
    logic [2:0]  E_MDUOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_Req;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_Start(E_Start), .E_MDUOp(E_MDUOp),
        .E_A(E_A), .E_B(E_B), .E_Req(E_Req),
        .E_Busy(E_Busy), .E_HI(E_HI), .E_LO(E_LO)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Present one cycle of inputs, advance the model across the edge, check at negedge.
    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rq);
        longint la;
        longint lb;
        longint res;
        logic [63:0] u;
        E_Start = s; E_MDUOp = op; E_A = a; E_B = b; E_Req = rq;
        @(posedge clk);
        cyc++;
        if (cyc == done_cyc) begin
            m_hi = p_hi;
            m_lo = p_lo;
        end
        if (s && !rq && !((cyc - 1) < done_cyc)) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            case (op)
                3'd1: begin res = la * lb; p_hi = res[63:32]; p_lo = res[31:0]; done_cyc = cyc + MC; end
                3'd2: begin u = {32'd0, a} * {32'd0, b}; p_hi = u[63:32]; p_lo = u[31:0]; done_cyc = cyc + MC; end
                3'd3: begin
                    if (b == 32'd0) begin p_hi = m_hi; p_lo = m_lo; end
                    else begin res = la / lb; p_lo = res[31:0]; res = la % lb; p_hi = res[31:0]; end
                    done_cyc = cyc + DC;
                end
                3'd4: begin
                    if (b == 32'd0) begin p_hi = m_hi; p_lo = m_lo; end
                    else begin p_lo = a / b; p_hi = a % b; end
                    done_cyc = cyc + DC;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
        @(negedge clk);
        check_eq("busy", {31'd0, E_Busy}, {31'd0, (cyc < done_cyc)});
        check_eq("hi", E_HI, m_hi);
        check_eq("lo", E_LO, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; E_Start = 1'b0; E_MDUOp = 3'd0; E_A = 32'd0; E_B = 32'd0; E_Req = 1'b0;
        #3 reset = 1'b0;
        #1;
        check_eq("rst_busy", {31'd0, E_Busy}, 32'd0);
        check_eq("rst_hi", E_HI, 32'd0);
        check_eq("rst_lo", E_LO, 32'd0);
        @(posedge clk); cyc++;
        @(negedge clk);
        reset = 1'b1;
        done_cyc = cyc;

        // mult / multu of -2 x 3
        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC);
        check_eq("mult_hi", E_HI, 32'hFFFF_FFFF);
        check_eq("mult_lo", E_LO, 32'hFFFF_FFFA);
        step(1'b1, 3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC);
        check_eq("multu_hi", E_HI, 32'h0000_0002);
        check_eq("multu_lo", E_LO, 32'hFFFF_FFFA);

        // div -7 / 2, then overflow case
        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC);
        check_eq("div_lo", E_LO, 32'hFFFF_FFFD);
        check_eq("div_hi", E_HI, 32'hFFFF_FFFF);
        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DC);
        check_eq("divov_lo", E_LO, 32'h8000_0000);
        check_eq("divov_hi", E_HI, 32'd0);

        // divu by zero keeps HI/LO
        step(1'b1, 3'd5, 32'h11, 32'd0, 1'b0);
        step(1'b1, 3'd6, 32'h22, 32'd0, 1'b0);
        step(1'b1, 3'd4, 32'd7, 32'd0, 1'b0);
        idle(DC);
        check_eq("div0_hi", E_HI, 32'h11);
        check_eq("div0_lo", E_LO, 32'h22);

        // mthi / mtlo back to back
        step(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        check_eq("mthi", E_HI, 32'h1234_5678);
        step(1'b1, 3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check_eq("mtlo", E_LO, 32'h9ABC_DEF0);

        // start while busy is ignored
        step(1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
        step(1'b1, 3'd6, 32'hDEAD, 32'd0, 1'b0);
        idle(MC - 1);
        check_eq("busy_ign_lo", E_LO, 32'h0000_000C);

        // E_Req drops only the same-cycle op
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        step(1'b1, 3'd5, 32'h55, 32'd0, 1'b1);
        idle(DC - 1);
        check_eq("req_div_lo", E_LO, 32'd14);
        check_eq("req_div_hi", E_HI, 32'd2);
        step(1'b1, 3'd1, 32'd9, 32'd9, 1'b1);
        check_eq("req_mult_busy", {31'd0, E_Busy}, 32'd0);
        idle(MC);

        // reset mid-flight: abandoned op never commits
        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_busy", {31'd0, E_Busy}, 32'd0);
        check_eq("mid_rst_hi", E_HI, 32'd0);
        check_eq("mid_rst_lo", E_LO, 32'd0);
        @(posedge clk); cyc++;
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
        done_cyc = cyc;
        idle(MC + 3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick(), pick(),
                 ($urandom_range(0, 7) == 0));
        end
        idle(DC + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage. Owns the HI/LO register pair.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models fixed multi-cycle latency with a busy counter.
- Drives HI/LO to the E-stage result mux for mfhi/mflo, and E_Busy to the D-stage stall logic.
- Forms the write side of the HI/LO state, complementing the general register file's read/write ports.

Parameters:
MULT_CYCLES, 5, cycles E_Busy stays high after a mult/multu start
DIV_CYCLES, 10, cycles E_Busy stays high after a div/divu start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state while 0
E_Start  input  1  E-stage instruction is an MDU op this cycle
E_MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
E_A  input  32  rs operand (dividend / multiplicand / mthi/mtlo source)
E_B  input  32  rt operand (divisor / multiplier)
E_Req  input  1  exception/interrupt request from M; suppresses the E-stage op this cycle
E_Busy  output  1  operation in flight
E_HI  output  32  architectural HI
E_LO  output  32  architectural LO

Behaviour:
- Reset (reset==0, asynchronous):
  - HI, LO, pending-result registers and counter all cleared to 0.
  - E_Busy=0 immediately.
  - Any in-flight op is abandoned and never commits.
- Accept condition: an op is accepted on a rising edge only if E_Start==1 && E_Req==0 && counter==0.
  - Any other combination, including E_Start while busy and op 0/7, is ignored with no state change.
  - The D-stage stall logic prevents start-while-busy; the block still ignores it.
- States: IDLE (counter==0), BUSY (counter!=0). E_Busy = (counter!=0), purely from registered state.
- mult/multu accepted at edge T:
  - 64-bit product latched into pending {hi,lo}; counter<=MULT_CYCLES.
  - mult uses signed 32x32; multu uses unsigned.
- div/divu accepted at edge T:
  - Pending lo<=quotient, hi<=remainder; counter<=DIV_CYCLES.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Divisor 0: pending hi/lo <= current HI/LO, so the commit leaves them unchanged. Latency and E_Busy still apply.
- Counting: each edge with counter!=0 decrements the counter. At the edge where counter==1, pending values are written to HI/LO.
  - E_Busy is high for exactly N cycles following edge T.
  - New HI/LO are visible in the first cycle E_Busy is low again.
- mthi/mtlo accepted at edge T: HI (or LO) <= E_A at that edge. No busy cycles, counter stays 0, other register untouched.
- E_HI/E_LO always reflect the architectural registers. During BUSY they hold the old values; there is no bypass of pending values.
- E_Req: affects only the op presented in the same cycle. An op already in flight continues and commits, because its instruction has already passed the exception point.
- Pending registers hold their value after commit until the next accepted mult/div.

Test Plan:
- Reset low mid-sequence, then high → E_Busy=0, E_HI=E_LO=0 immediately on assertion; no later commit appears.
- mult E_A=0xFFFFFFFE (-2), E_B=3 → E_Busy high for 5 cycles; then E_HI=0xFFFFFFFF, E_LO=0xFFFFFFFA. Same operands with multu → E_HI=0x00000002, E_LO=0xFFFFFFFA.
- div E_A=0xFFFFFFF9 (-7), E_B=2 → E_Busy high for 10 cycles; then E_LO=0xFFFFFFFD, E_HI=0xFFFFFFFF. divu 7/0 with HI=0x11, LO=0x22 → busy 10 cycles, HI/LO unchanged.
- mthi E_A=0x12345678, next cycle mtlo E_A=0x9ABCDEF0 → E_HI=0x12345678 after the first edge, E_LO=0x9ABCDEF0 after the second; E_Busy never high.
- mult 3x4 started; a second E_Start (mtlo 0xDEAD) issued while busy → ignored; after 5 cycles E_LO=0x0000000C.
- div accepted, then E_Req=1 with E_Start mthi 0x55 → mthi dropped; the div still commits after 10 cycles. E_Req=1 on a mult start → no busy, HI/LO unchanged.
